// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the ARM load/store-multiple sequencer.
package ldm_stm_sequencer_pkg;

  typedef enum logic [1:0] {StIdle, StXfer, StFinish} state_e;

  // IR field positions
  localparam int unsigned IrPBit    = 24;
  localparam int unsigned IrUBit    = 23;
  localparam int unsigned IrWBit    = 21;
  localparam int unsigned IrLBit    = 20;
  localparam int unsigned IrListLsb = 0;

  // Addressing modes encoded as {P, U}
  localparam logic [1:0] ModeIa = 2'b01;
  localparam logic [1:0] ModeIb = 2'b11;
  localparam logic [1:0] ModeDa = 2'b00;
  localparam logic [1:0] ModeDb = 2'b10;

  localparam int unsigned WordBytes = 4;

endpackage

// File: rtl/ldm_stm_sequencer_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit plus a nonzero flag.
module ldm_stm_sequencer_lowest_set_bit #(
  parameter int unsigned Width = 16,
  parameter int unsigned IdxW  = $clog2(Width)
) (
  input  logic [Width-1:0] vec_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             nonzero_o
);

  always_comb begin
    idx_o = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IdxW'(i);
    end
    nonzero_o = |vec_i;
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Walks an LDM/STM register list, issuing one register/address per transfer,
// then a one-cycle completion with the base-writeback value.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int unsigned AddrW = 32,
  parameter int unsigned ListW = 16,
  parameter int unsigned RegW  = $clog2(ListW)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [31:0]      ir_i,
  input  logic [AddrW-1:0] base_i,
  input  logic             mem_ready_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [RegW-1:0]  reg_num_o,
  output logic [AddrW-1:0] addr_o,
  output logic             load_o,
  output logic             wb_en_o,
  output logic [AddrW-1:0] wb_value_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(ListW + 1);

  state_e           state_q, state_d;
  logic [ListW-1:0] list_q, list_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [AddrW-1:0] wb_q, wb_d;
  logic             load_q, load_d;
  logic             w_q, w_d;

  logic [ListW-1:0] start_list;
  logic [CntW-1:0]  n_regs;
  logic [AddrW-1:0] total_off;
  logic [ListW-1:0] list_rem;
  logic [ListW-1:0] empty_test_vec;
  logic [RegW-1:0]  cur_idx;
  logic             cur_nonzero_unused;
  logic [RegW-1:0]  next_idx_unused;
  logic             next_nonzero;
  logic             unused_ir;

  assign start_list = ir_i[IrListLsb +: ListW];
  assign unused_ir  = ^{ir_i[31:25], ir_i[22], ir_i[19:16]};

  always_comb begin
    n_regs = '0;
    for (int i = 0; i < ListW; i++) begin
      n_regs = n_regs + CntW'(start_list[i]);
    end
    total_off = AddrW'(n_regs) * AddrW'(WordBytes);
  end

  // Lowest set bit cleared: what remains after the current transfer.
  assign list_rem       = list_q & (list_q - ListW'(1));
  assign empty_test_vec = (state_q == StIdle) ? start_list : list_rem;

  ldm_stm_sequencer_lowest_set_bit #(
    .Width (ListW),
    .IdxW  (RegW)
  ) u_cur_lsb (
    .vec_i     (list_q),
    .idx_o     (cur_idx),
    .nonzero_o (cur_nonzero_unused)
  );

  ldm_stm_sequencer_lowest_set_bit #(
    .Width (ListW),
    .IdxW  (RegW)
  ) u_next_lsb (
    .vec_i     (empty_test_vec),
    .idx_o     (next_idx_unused),
    .nonzero_o (next_nonzero)
  );

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    wb_d    = wb_q;
    load_d  = load_q;
    w_d     = w_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          list_d = start_list;
          load_d = ir_i[IrLBit];
          w_d    = ir_i[IrWBit];
          wb_d   = ir_i[IrUBit] ? base_i + total_off : base_i - total_off;
          unique case ({ir_i[IrPBit], ir_i[IrUBit]})
            ModeIa:  addr_d = base_i;
            ModeIb:  addr_d = base_i + AddrW'(WordBytes);
            ModeDa:  addr_d = base_i - total_off + AddrW'(WordBytes);
            ModeDb:  addr_d = base_i - total_off;
            default: addr_d = base_i;
          endcase
          state_d = next_nonzero ? StXfer : StFinish;
        end
      end
      StXfer: begin
        if (mem_ready_i) begin
          list_d  = list_rem;
          addr_d  = addr_q + AddrW'(WordBytes);
          state_d = next_nonzero ? StXfer : StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      list_q  <= '0;
      addr_q  <= '0;
      wb_q    <= '0;
      load_q  <= 1'b0;
      w_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      wb_q    <= wb_d;
      load_q  <= load_d;
      w_q     <= w_d;
    end
  end

  always_comb begin
    busy_o     = (state_q != StIdle);
    valid_o    = (state_q == StXfer);
    done_o     = (state_q == StFinish);
    reg_num_o  = valid_o ? cur_idx : '0;
    addr_o     = valid_o ? addr_q : '0;
    load_o     = load_q;
    wb_en_o    = done_o & w_q;
    wb_value_o = done_o ? wb_q : '0;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
Multi-cycle sequencer for ARM Load/Store Multiple (IR[27:25]=3'b100). The shifter supplies only the total offset, 4 × popcount(register list); this block walks that register list. It emits one register number and word address per transfer toward the register file/memory interface, then a base-writeback value. It sits between control unit and memory port and stalls the pipeline while BUSY.

Parameters:
ADDR_W, 32, address/base width
LIST_W, 16, register-list width (IR[15:0])

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
START  in  1  begin sequence; sampled only in IDLE
IR  in  32  instruction word; P=IR[24], U=IR[23], W=IR[21], L=IR[20], list=IR[15:0]
BASE  in  32  value of Rn, sampled with START
MEM_READY  in  1  memory accepts/completes current transfer
BUSY  out  1  high from cycle after START until DONE cycle inclusive
VALID  out  1  transfer request valid
REG_NUM  out  4  register for current transfer
ADDR  out  32  word address for current transfer
LOAD  out  1  latched L bit (1=LDM, 0=STM)
WB_EN  out  1  one-cycle base writeback strobe (latched W)
WB_VALUE  out  32  new Rn value, valid when WB_EN
DONE  out  1  one-cycle completion pulse

Behaviour:
- Single clock CLK. RESET is synchronous, active-high. Reset outputs: BUSY=0, VALID=0, REG_NUM=0, ADDR=0, LOAD=0, WB_EN=0, WB_VALUE=0, DONE=0. State goes to IDLE.
- States: IDLE, XFER, FINISH.
- IDLE: on START=1, latch the list, P, U, W, L, and BASE. Compute n=popcount(list).
  - Compute start address: IA (P=0,U=1) = BASE; IB (P=1,U=1) = BASE+4; DA (P=0,U=0) = BASE−4n+4; DB (P=1,U=0) = BASE−4n.
  - Compute writeback: U ? BASE+4n : BASE−4n.
  - Go to XFER, or to FINISH if the list is 0.
- Registers are always visited in ascending order, lowest-numbered at the lowest address, regardless of U.
- XFER: VALID=1; REG_NUM = lowest set bit of the remaining list; ADDR = current address.
  - REG_NUM and ADDR are held stable until MEM_READY=1 is sampled.
  - On VALID&MEM_READY: clear that bit and ADDR += 4. If the remaining list becomes 0, go to FINISH in the same edge.
  - VALID is never deasserted before acceptance.
- FINISH: one cycle. DONE=1, WB_EN=W, WB_VALUE as computed, VALID=0. Then go to IDLE; BUSY drops the following cycle.
- Latency: START at cycle 0 gives first VALID at cycle 1. With MEM_READY held at 1, DONE occurs at cycle n+1.
- Empty list: no transfers. DONE and WB_EN (if W) occur at cycle 1, with WB_VALUE=BASE.
- START while BUSY is ignored; IR and BASE are don't-care outside the START cycle.
- Arithmetic is modulo 2^32; address wrap past 0xFFFFFFFC wraps silently.
- RESET mid-sequence aborts immediately: no DONE, no WB_EN. START in the same cycle as RESET is ignored.
- MEM_READY outside XFER is ignored.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/XFER/FINISH)
  - IR field bit positions (P, U, W, L, list)
  - mode constants (IA/IB/DA/DB as {P,U})
  - the word-size constant 4
- One sub-module, lowest_set_bit: combinational 16-to-4 priority encoder plus a nonzero flag. It is used for REG_NUM and for the list-empty test.
- Popcount lives in the top module (shared intent with the shifter's multiple offset).

Test Plan:
- LDMIA R0!,{R1,R3}: IR=0xE8B0000A, BASE=0x100, MEM_READY=1 → (REG 1, ADDR 0x100), then (REG 3, ADDR 0x104), LOAD=1; DONE at cycle 3 with WB_EN=1, WB_VALUE=0x108.
- STMDB R13!,{R4,R5,R14}: IR=0xE92D4030, BASE=0x1000 → R4@0xFF4, R5@0xFF8, R14@0xFFC, LOAD=0; WB_VALUE=0xFF4.
- IB without writeback: IR=0xE9900003, BASE=0x200 → R0@0x204, R1@0x208; DONE with WB_EN=0. DA: IR=0xE8100003, BASE=0x200 → R0@0x1FC, R1@0x200.
- Backpressure: MEM_READY low for 3 cycles on the first transfer → REG_NUM/ADDR/VALID stable for those cycles; advances only after MEM_READY=1.
- Empty list IR=0xE8A00000, BASE=0x40 → VALID never high; DONE and WB_EN at cycle 1 with WB_VALUE=0x40. Full list 0xFFFF, IA, BASE=0 → 16 transfers R0..R15 at 0x00..0x3C; WB_VALUE=0x40.
- RESET asserted during the second transfer of a 3-register STM → next cycle all outputs 0 and state IDLE, no DONE. A START during BUSY is ignored, and the sequence count is unchanged.
